// File: rtl/vga_color_line_if.sv
// Colour-in / VGA-out bundle for vga_color_line.
// master: application side driving RGB; slave: the raster generator.
interface vga_color_line_if;
  logic [11:0] RGB;
  logic        VGA_HSYNC;
  logic        VGA_VSYNC;
  logic [3:0]  VGA_RED;
  logic [3:0]  VGA_GREEN;
  logic [3:0]  VGA_BLUE;

  modport master (
    output RGB,
    input  VGA_HSYNC, VGA_VSYNC, VGA_RED, VGA_GREEN, VGA_BLUE
  );

  modport slave (
    input  RGB,
    output VGA_HSYNC, VGA_VSYNC, VGA_RED, VGA_GREEN, VGA_BLUE
  );
endinterface

// File: rtl/vga_color_line.sv
// Single-colour VGA raster generator: pixel-rate divider, H/V counters, registered sync and colour.
// Optional macro VGA_BORDER_LINE_EN draws a white one-pixel frame around the visible area.
module vga_color_line #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic             CLK,
  input  logic             RST_N,
  vga_color_line_if.slave  vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   HS_FIRST = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   VS_FIRST = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
`ifdef VGA_BORDER_LINE_EN
  localparam logic [H_W-1:0]   H_EDGE   = H_W'(H_ACTIVE - 1);
  localparam logic [V_W-1:0]   V_EDGE   = V_W'(V_ACTIVE - 1);
`endif

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [H_W-1:0]   h_cnt_q, h_cnt_d;
  logic [V_W-1:0]   v_cnt_q, v_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [11:0]      colour_q, colour_d;
  logic             pix_en;
  logic             active;
  logic [11:0]      pix_rgb;

  // Outputs are computed from the pre-increment counters, giving one pixel tick of latency.
  always_comb begin
    div_cnt_d = div_cnt_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    colour_d  = colour_q;

    pix_en  = (div_cnt_q == DIV_LAST);
    active  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    pix_rgb = vga.RGB;
`ifdef VGA_BORDER_LINE_EN
    if ((h_cnt_q == '0) || (h_cnt_q == H_EDGE) || (v_cnt_q == '0) || (v_cnt_q == V_EDGE)) begin
      pix_rgb = '1;
    end
`endif

    div_cnt_d = pix_en ? '0 : div_cnt_q + DIV_W'(1);

    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + V_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + H_W'(1);
      end
      hsync_d  = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
      vsync_d  = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
      colour_d = active ? pix_rgb : '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      colour_q  <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      colour_q  <= colour_d;
    end
  end

  assign vga.VGA_HSYNC = hsync_q;
  assign vga.VGA_VSYNC = vsync_q;
  assign vga.VGA_RED   = colour_q[11:8];
  assign vga.VGA_GREEN = colour_q[7:4];
  assign vga.VGA_BLUE  = colour_q[3:0];

endmodule

// File: tb/tb_vga_color_line.sv
// Directed bench for vga_color_line: default horizontal timing, shortened vertical timing
// (6 active + 2 FP + 2 sync + 2 BP = 12 lines) so whole frames fit in a short run.
module tb_vga_color_line;
  logic clk = 1'b0;
  logic rst_n;
  int unsigned edge_cnt;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  vga_color_line_if bus ();

  vga_color_line #(
    .CLK_DIV (4),
    .V_ACTIVE(6),
    .V_FP    (2),
    .V_SYNC  (2),
    .V_BP    (2)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .vga  (bus)
  );

  always #5 clk = ~clk;

  // Number of rising edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Sync edge monitor: edge numbers of the first two falls and first rise.
  int unsigned hs_fall_e[2], vs_fall_e[2];
  int unsigned hs_fall_n, vs_fall_n, hs_rise_e, vs_rise_e;
  bit hs_rose, vs_rose;
  logic hs_prev, vs_prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      hs_fall_e[0] = 0; hs_fall_e[1] = 0; vs_fall_e[0] = 0; vs_fall_e[1] = 0;
      hs_fall_n = 0; vs_fall_n = 0; hs_rise_e = 0; vs_rise_e = 0;
      hs_rose = 1'b0; vs_rose = 1'b0; hs_prev = 1'b1; vs_prev = 1'b1;
    end else begin
      if (hs_prev && !bus.VGA_HSYNC) begin
        if (hs_fall_n < 2) hs_fall_e[hs_fall_n] = edge_cnt;
        hs_fall_n++;
      end
      if (!hs_prev && bus.VGA_HSYNC && !hs_rose) begin hs_rise_e = edge_cnt; hs_rose = 1'b1; end
      if (vs_prev && !bus.VGA_VSYNC) begin
        if (vs_fall_n < 2) vs_fall_e[vs_fall_n] = edge_cnt;
        vs_fall_n++;
      end
      if (!vs_prev && bus.VGA_VSYNC && !vs_rose) begin vs_rise_e = edge_cnt; vs_rose = 1'b1; end
      hs_prev = bus.VGA_HSYNC;
      vs_prev = bus.VGA_VSYNC;
    end
  end

  typedef struct {
    int unsigned edge_n;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic [11:0] col;
  } vec_t;

  vec_t vecs[24];

  task automatic wait_edge(input int unsigned n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [13:0] exp_v);
    logic [13:0] act;
    act = {bus.VGA_HSYNC, bus.VGA_VSYNC, bus.VGA_RED, bus.VGA_GREEN, bus.VGA_BLUE};
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got hs/vs/rgb=%b/%b/%h want %b/%b/%h", name,
               act[13], act[12], act[11:0], exp_v[13], exp_v[12], exp_v[11:0]);
    end
  endtask

  task automatic chk_int(input string name, input int unsigned act, input int unsigned exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp_v);
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] exp_col;
    int unsigned pix, h, v;

    // edge_n: edge after which the outputs are sampled; pixel p is shown after edge 4*(p+1).
    vecs[0]  = '{3,     12'hFFF, 1'b1, 1'b1, 12'h000};  // no pixel tick yet
    vecs[1]  = '{4,     12'h000, 1'b1, 1'b1, 12'h000};  // (0,0)
    vecs[2]  = '{52,    12'h0F0, 1'b1, 1'b1, 12'h0F0};  // (12,0)
    vecs[3]  = '{100,   12'h00F, 1'b1, 1'b1, 12'h00F};  // (24,0)
    vecs[4]  = '{152,   12'hF00, 1'b1, 1'b1, 12'hF00};  // (37,0)
    vecs[5]  = '{2556,  12'hFFF, 1'b1, 1'b1, 12'hFFF};  // (638,0)
    vecs[6]  = '{2560,  12'hFFF, 1'b1, 1'b1, 12'hFFF};  // (639,0)
    vecs[7]  = '{2564,  12'hFFF, 1'b1, 1'b1, 12'h000};  // (640,0)
    vecs[8]  = '{2624,  12'hFFF, 1'b1, 1'b1, 12'h000};  // (655,0)
    vecs[9]  = '{2628,  12'hFFF, 1'b0, 1'b1, 12'h000};  // (656,0)
    vecs[10] = '{3008,  12'hFFF, 1'b0, 1'b1, 12'h000};  // (751,0)
    vecs[11] = '{3012,  12'hFFF, 1'b1, 1'b1, 12'h000};  // (752,0)
    vecs[12] = '{3200,  12'hFFF, 1'b1, 1'b1, 12'h000};  // (799,0)
    vecs[13] = '{3208,  12'h5A3, 1'b1, 1'b1, 12'h5A3};  // (1,1)
    vecs[14] = '{16404, 12'h123, 1'b1, 1'b1, 12'h123};  // (100,5)
    vecs[15] = '{19604, 12'hFFF, 1'b1, 1'b1, 12'h000};  // (100,6)
    vecs[16] = '{25600, 12'hFFF, 1'b1, 1'b1, 12'h000};  // (799,7)
    vecs[17] = '{25604, 12'hFFF, 1'b1, 1'b0, 12'h000};  // (0,8)
    vecs[18] = '{31604, 12'hFFF, 1'b0, 1'b0, 12'h000};  // (700,9)
    vecs[19] = '{32004, 12'hFFF, 1'b1, 1'b1, 12'h000};  // (0,10)
    vecs[20] = '{38400, 12'hFFF, 1'b1, 1'b1, 12'h000};  // (799,11)
    vecs[21] = '{38412, 12'h0F0, 1'b1, 1'b1, 12'h0F0};  // (2,0) next frame
    vecs[22] = '{38414, 12'hF00, 1'b1, 1'b1, 12'h0F0};  // between ticks: holds
    vecs[23] = '{38416, 12'hF00, 1'b1, 1'b1, 12'hF00};  // (3,0)

    rst_n = 1'b0;
    bus.RGB = 12'h000;
    repeat (5) begin
      @(negedge clk);
      chk("reset_hold", {1'b1, 1'b1, 12'h000});
    end
    rst_n = 1'b1;

    // Mid-frame asynchronous reset at pixel (700,3), inside the HSYNC pulse.
    bus.RGB = 12'hFFF;
    wait_edge(12404);
    chk("pre_reset_hsync_low", {1'b0, 1'b1, 12'h000});
    rst_n = 1'b0;
    #1;
    chk("async_reset", {1'b1, 1'b1, 12'h000});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      wait_edge(vecs[i].edge_n - 1);
      bus.RGB = vecs[i].rgb;
      wait_edge(vecs[i].edge_n);
      exp_col = vecs[i].col;
`ifdef VGA_BORDER_LINE_EN
      if (vecs[i].edge_n >= 4) begin
        pix = vecs[i].edge_n / 4 - 1;
        h = pix % 800;
        v = (pix / 800) % 12;
        if (h < 640 && v < 6 && (h == 0 || h == 639 || v == 0 || v == 5)) exp_col = 12'hFFF;
      end
`else
      pix = 0; h = 0; v = 0;
`endif
      chk($sformatf("vec%0d_edge%0d", i, vecs[i].edge_n), {vecs[i].hs, vecs[i].vs, exp_col});
    end

    // Let the second VSYNC pulse begin, then check recorded sync edges.
    wait_edge(64008);
    chk_int("hsync_first_fall", hs_fall_e[0], 2628);
    chk_int("hsync_low_width", hs_rise_e - hs_fall_e[0], 384);
    chk_int("hsync_period", hs_fall_e[1] - hs_fall_e[0], 3200);
    chk_int("vsync_first_fall", vs_fall_e[0], 25604);
    chk_int("vsync_low_width", vs_rise_e - vs_fall_e[0], 6400);
    chk_int("frame_period", vs_fall_e[1] - vs_fall_e[0], 38400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vga_color_line.md
# vga_color_line

Single-colour VGA raster generator for the Piano display path. It derives a pixel-rate enable from the system clock and produces 640×480@60 Hz sync timing. During the visible area it drives the 12-bit colour presented on `RGB`; during blanking it drives black. It sits between the application colour logic and the board's 4-bit-per-channel VGA DAC pins.

## Interface
- `CLK_DIV`, default 4: system clocks per pixel; 100 MHz system clock gives a 25 MHz pixel rate.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, defaults 640/16/96/48: horizontal timing in pixels.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, defaults 480/10/2/33: vertical timing in lines.
- `CLK`, input, 1 bit: system clock; the single clock, rising edge.
- `RST_N`, input, 1 bit: reset, asynchronous, active-low.
- `RGB`, input, 12 bits: colour to display, laid out {R[11:8], G[7:4], B[3:0]}; sampled every pixel tick.
- `VGA_HSYNC`, output, 1 bit: horizontal sync, active-low.
- `VGA_VSYNC`, output, 1 bit: vertical sync, active-low.
- `VGA_RED`, output, 4 bits: red channel.
- `VGA_GREEN`, output, 4 bits: green channel.
- `VGA_BLUE`, output, 4 bits: blue channel.

## Operation
- **Divider:** `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_en` = (`div_cnt` == CLK_DIV-1).
- **Horizontal counter:** `h_cnt` counts 0..H_TOTAL-1, where H_TOTAL = 800. It advances on `pix_en` and wraps to 0.
- **Vertical counter:** `v_cnt` counts 0..V_TOTAL-1, where V_TOTAL = 525. It advances on `pix_en` when `h_cnt` == H_TOTAL-1, and wraps to 0 after line 524.
- **Active area:** `active` = (`h_cnt` < 640) && (`v_cnt` < 480).
- **HSYNC:** low when 656 ≤ `h_cnt` ≤ 751; high otherwise.
- **VSYNC:** low when 490 ≤ `v_cnt` ≤ 491; high otherwise.
- **Colour:** when `active`, {`VGA_RED`, `VGA_GREEN`, `VGA_BLUE`} = `RGB`; otherwise 0.
- All counter widths are sized to hold their maximum value. There is no arithmetic overflow beyond the defined wrap points.
- `RGB` changes may occur at any CLK edge. Only the value present at a pixel tick is displayed; no synchronisation is applied, because `RGB` is in the same clock domain.

## Timing
- **Reset value of every output:** `VGA_HSYNC`=1, `VGA_VSYNC`=1, `VGA_RED`/`VGA_GREEN`/`VGA_BLUE`=0. Counters `div_cnt`, `h_cnt`, `v_cnt` are all 0.
- **Reset assertion:** asynchronous; outputs take their reset values immediately, mid-frame included.
- **After reset release:** the first `pix_en` occurs on the CLK_DIV-th rising edge.
- **Output registers:** all outputs are registered and update only on CLK edges where `pix_en`=1.
- **Output update rule:** each update is computed from the pre-increment (`h_cnt`, `v_cnt`) and the current `RGB`. This gives one pixel tick of latency.
- **Line period:** 800 × CLK_DIV CLK = 3200 CLK. HSYNC low width is 96 × CLK_DIV = 384 CLK.
- **Frame period:** 525 lines = 1,680,000 CLK. VSYNC low width is 2 lines = 6400 CLK.
- **Colour propagation:** an `RGB` change reaches the outputs within CLK_DIV CLK edges, provided the displayed pixel is active.

## Configuration
- Macro: `VGA_BORDER_LINE_EN`.
- **Defined:** pixels with `h_cnt` ∈ {0, 639} or `v_cnt` ∈ {0, 479} output white (F/F/F) regardless of `RGB`. All other active pixels output `RGB`.
- **Undefined:** every active pixel outputs `RGB`; there is no border.
- The macro has no effect on sync timing or blanking.

## Test plan
- **Reset hold:** hold `RST_N`=0 for 5 CLK with `RGB`=0 → `VGA_HSYNC`=1, `VGA_VSYNC`=1, all colours 0 throughout.
- **Colour sequence:** release reset; step `RGB` through 0x000, 0x0F0, 0x00F, 0xF00, each held 50 CLK. Within 4 CLK of each change, line 0 shows R/G/B = 0/0/0, 0/F/0, 0/0/F, F/0/0. Covers border macro undefined; with the macro, use pixels other than 0/639.
- **HSYNC timing:** run one full line → HSYNC falls at `h_cnt`=656, stays low exactly 384 CLK, and repeats every 3200 CLK.
- **Horizontal blanking:** `RGB`=0xFFF → colours read 0 for `h_cnt` 640..799 and F/F/F for 1..638.
- **Frame timing:** run one full frame → VSYNC low exactly 6400 CLK starting at `v_cnt`=490. Colours are 0 for all of lines 480..524. Frame period is 1,680,000 CLK.
- **Mid-frame reset:** assert `RST_N`=0 at `h_cnt`≈700, `v_cnt`≈100 → outputs go to reset values without waiting for a clock edge. After release the frame restarts from `h_cnt`=`v_cnt`=0.
